toff_seq_ctrl: RTL and testbench
================================

Name: toff_seq_ctrl

Overview:
- Sequencer that evaluates a reversible circuit by applying a stored program of Toffoli operations, one per cycle, to an NBITS-wide bit register.
- Each entry may force either control to constant 1, so one engine covers NOT (both forced), CNOT (one forced) and full Toffoli (AND/NAND with target preset).
- Runs forward or in reverse order; Toffoli is self-inverse, so reverse execution uncomputes.
- Sits between the host and the shared Toffoli datapath; one program runs at a time.

Parameters:
- NBITS, 8, width of the bit register.
- AW, 3, bit-index width; must equal clog2(NBITS).
- DEPTH, 8, number of program entries.
- PW, 3, program address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  PW  program entry address.
- prog_ca  in  AW  control-a bit index.
- prog_cb  in  AW  control-b bit index.
- prog_tg  in  AW  target bit index.
- prog_ua  in  1  1 = control a forced to constant 1.
- prog_ub  in  1  1 = control b forced to constant 1.
- start  in  1  launch request, sampled only in IDLE.
- dir  in  1  0 = forward (entry 0 upward), 1 = reverse; sampled with start.
- len  in  PW+1  number of entries to run; sampled with start; values above DEPTH clamp to DEPTH.
- data_in  in  NBITS  initial register value; sampled with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  illegal-entry flag; sticky until the next accepted start.
- state_out  out  NBITS  current register contents, registered.

Behaviour:
- Reset (rst_n = 0 at a clk edge): state = IDLE; busy = 0; done = 0; err = 0; state_out = 0; pc and count = 0; all program entries cleared to zero. Reset overrides everything, including mid-RUN; the run is aborted and no done is produced.
- Program write: when prog_we = 1 in IDLE, the entry at prog_addr is written at the clock edge. prog_we in RUN or DONE is ignored.
- FSM states:
  - IDLE: on start = 1, load reg = data_in, clear err, count = min(len, DEPTH), pc = (dir ? count-1 : 0). If count = 0, go to DONE; otherwise go to RUN.
  - RUN: each cycle, execute entry[pc]:
    - effective A = ua ? 1 : reg[ca]; effective B = ub ? 1 : reg[cb].
    - reg[tg] <= reg[tg] ^ (A & B).
    - pc steps +1 (forward) or -1 (reverse); count decrements.
    - After the entry that brings count to 0, go to DONE.
  - DONE: done = 1 for exactly this one cycle, then IDLE.
- Illegal entry: (!ua and tg == ca) or (!ub and tg == cb). When executed, reg is left unchanged by that entry, err = 1, and the FSM jumps to DONE; remaining entries are skipped. An all-zero (cleared) entry is illegal.
- state_out mirrors reg, updated on the same edge as reg.
- Latency, with start accepted at edge T:
  - len > 0 and no error: done is high in the cycle after edge T+len (the DONE cycle); state_out is final at that point.
  - len = 0: done is high in the cycle after edge T; state_out = data_in.
- start while busy is ignored. pc never leaves 0..DEPTH-1, and no wrap-around occurs.

Test Plan:
- Single NOT: entry0 = {ua=1, ub=1, tg=2}, len=1, dir=0, data_in=0x00 -> done one cycle after edge T+1; state_out = 0x04; err = 0.
- OR from NOT/NOT/NAND: entry0 = {ua=ub=1, tg=0}, entry1 = {ua=ub=1, tg=1}, entry2 = {ca=0, cb=1, tg=2}, len=3:
  - data_in=0x04 (a=0, b=0) -> state_out = 0x03 (bit2 = OR = 0).
  - data_in=0x06 (a=0, b=1) -> state_out = 0x05 (bit2 = 1).
  - data_in=0x07 (a=1, b=1) -> state_out = 0x04 (bit2 = 1).
- Uncompute: run the OR program forward with data_in=0x06 (result 0x05), then start with dir=1, data_in=0x05 -> state_out = 0x06, done after 3 RUN cycles.
- Illegal entry: entry0 = {ua=ub=1, tg=1}, entry1 = {ca=3, cb=0, tg=3, ua=0}, len=2, data_in=0x00 -> err = 1, state_out = 0x02, done one cycle after edge T+2. err clears on the next accepted start.
- Ignored requests: len=0 with data_in=0xA5 -> done one cycle after edge T, state_out = 0xA5. During a len=3 run, pulse start and prog_we -> no restart; program contents unchanged when read back in a later run.
- Reset mid-run: drop rst_n during RUN -> next cycle busy = 0, done = 0, err = 0, state_out = 0x00, and a subsequent run with the old program reports err (entries cleared).

Source files
------------

// File: rtl/toff_seq_ctrl.sv
// toff_seq_ctrl: runs a stored program of Toffoli operations, one per cycle,
// over an NBITS-wide bit register. A forced control (ua/ub) turns the same
// operation into NOT or CNOT. Since every Toffoli is self-inverse, running
// the same program in reverse order uncomputes a forward run.
module toff_seq_ctrl #(
    parameter int NBITS = 8,
    parameter int AW    = 3,   // must equal clog2(NBITS)
    parameter int DEPTH = 8,
    parameter int PW    = 3    // must equal clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog_we,
    input  logic [PW-1:0]    prog_addr,
    input  logic [AW-1:0]    prog_ca,
    input  logic [AW-1:0]    prog_cb,
    input  logic [AW-1:0]    prog_tg,
    input  logic             prog_ua,
    input  logic             prog_ub,
    input  logic             start,
    input  logic             dir,
    input  logic [PW:0]      len,
    input  logic [NBITS-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NBITS-1:0] state_out
);

    // One program entry: two control indices, one target index, and a
    // per-control flag that replaces that control with constant 1.
    typedef struct packed {
        logic [AW-1:0] ca;
        logic [AW-1:0] cb;
        logic [AW-1:0] tg;
        logic          ua;
        logic          ub;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PC_ONE  = PW'(1);

    entry_t        prog_mem [DEPTH];
    fsm_t          fsm;
    logic [PW-1:0] pc;
    logic [PW:0]   count;
    logic          run_dir;

    // Values derived from the entry under the program counter and from the
    // launch request.
    entry_t           cur;
    logic             eff_a;
    logic             eff_b;
    logic             illegal;
    logic [NBITS-1:0] next_reg;
    logic [PW:0]      len_clamped;
    logic [PW-1:0]    start_pc;

    // Decode the current entry, its legality and the register value it produces.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        cur      = prog_mem[pc];
        eff_a    = cur.ua ? 1'b1 : state_out[cur.ca];
        eff_b    = cur.ub ? 1'b1 : state_out[cur.cb];
        // A target that is also a live control would not be reversible.
        illegal  = (!cur.ua && (cur.tg == cur.ca)) ||
                   (!cur.ub && (cur.tg == cur.cb));
        next_reg = state_out;
        next_reg[cur.tg] = state_out[cur.tg] ^ (eff_a & eff_b);
    end

    // Clamp the requested length and pick the first entry for the chosen direction.
    always_comb begin
        len_clamped = (len > DEPTH_C) ? DEPTH_C : len;
        start_pc    = '0;
        if (dir && (len_clamped != '0)) begin
            start_pc = PW'(len_clamped - CNT_ONE);
        end
    end

    // Program store: written from the host only while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the program is part of the reset state, so the array is
            // cleared here; a cleared entry decodes as illegal.
            for (int i = 0; i < DEPTH; i++) begin
                prog_mem[i] <= '0;
            end
        end else if (prog_we && (fsm == S_IDLE)) begin
            prog_mem[prog_addr] <= '{ca: prog_ca, cb: prog_cb, tg: prog_tg,
                                     ua: prog_ua, ub: prog_ub};
        end
    end

    // Sequencer FSM with registered status outputs and the bit register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= S_IDLE;
            pc        <= '0;
            count     <= '0;
            run_dir   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            state_out <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register sees the pre-edge values of the others.
            done <= 1'b0;
            unique case (fsm)
                S_IDLE: begin
                    if (start) begin
                        state_out <= data_in;
                        err       <= 1'b0;
                        count     <= len_clamped;
                        pc        <= start_pc;
                        run_dir   <= dir;
                        busy      <= 1'b1;
                        if (len_clamped == '0) begin
                            fsm  <= S_DONE;
                            done <= 1'b1;
                        end else begin
                            fsm <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (illegal) begin
                        // Abort: register untouched, remaining entries skipped.
                        err  <= 1'b1;
                        fsm  <= S_DONE;
                        done <= 1'b1;
                    end else begin
                        state_out <= next_reg;
                        count     <= count - CNT_ONE;
                        if (count == CNT_ONE) begin
                            // Last entry: hold pc so it never steps past either end.
                            fsm  <= S_DONE;
                            done <= 1'b1;
                        end else if (run_dir) begin
                            pc <= pc - PC_ONE;
                        end else begin
                            pc <= pc + PC_ONE;
                        end
                    end
                end

                S_DONE: begin
                    fsm  <= S_IDLE;
                    busy <= 1'b0;
                end

                default: begin
                    fsm  <= S_IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toff_seq_ctrl.sv
// Bench for toff_seq_ctrl: a program-level reference model predicts the
// per-cycle outputs of each run; a compare process checks every cycle, and
// directed runs pin the model with hand-computed results.
module tb_toff_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [2:0] prog_ca;
    logic [2:0] prog_cb;
    logic [2:0] prog_tg;
    logic       prog_ua;
    logic       prog_ub;
    logic       start;
    logic       dir;
    logic [3:0] len;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] state_out;

    int checks = 0;
    int errors = 0;

    toff_seq_ctrl #(.NBITS(8), .AW(3), .DEPTH(8), .PW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_ca   (prog_ca),
        .prog_cb   (prog_cb),
        .prog_tg   (prog_tg),
        .prog_ua   (prog_ua),
        .prog_ub   (prog_ub),
        .start     (start),
        .dir       (dir),
        .len       (len),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       busy;
        bit       done;
        bit       err;
        bit [7:0] st;
    } obs_t;

    obs_t     exp_q[$];
    obs_t     cur;
    bit       valid = 1'b0;
    bit [2:0] m_ca[8];
    bit [2:0] m_cb[8];
    bit [2:0] m_tg[8];
    bit       m_ua[8];
    bit       m_ub[8];

    // Evaluate the whole program as a list of entries and queue the
    // outputs expected after each following clock edge.
    function automatic void plan_run(input bit d, input int l, input bit [7:0] data);
        int      n;
        int      idx;
        bit [7:0] st;
        bit      a;
        bit      b;
        n  = (l > 8) ? 8 : l;
        st = data;
        if (n == 0) begin
            cur = '{busy: 1, done: 1, err: 0, st: st};
            exp_q.push_back('{busy: 0, done: 0, err: 0, st: st});
            return;
        end
        cur = '{busy: 1, done: 0, err: 0, st: st};
        for (int k = 0; k < n; k++) begin
            idx = d ? (n - 1 - k) : k;
            if ((!m_ua[idx] && m_tg[idx] == m_ca[idx]) || (!m_ub[idx] && m_tg[idx] == m_cb[idx])) begin
                exp_q.push_back('{busy: 1, done: 1, err: 1, st: st});
                exp_q.push_back('{busy: 0, done: 0, err: 1, st: st});
                return;
            end
            a = m_ua[idx] ? 1'b1 : st[m_ca[idx]];
            b = m_ub[idx] ? 1'b1 : st[m_cb[idx]];
            st[m_tg[idx]] = st[m_tg[idx]] ^ (a & b);
            exp_q.push_back('{busy: 1, done: (k == n - 1), err: 0, st: st});
        end
        exp_q.push_back('{busy: 0, done: 0, err: 0, st: st});
    endfunction

    // Advance the model at each edge: pop a queued run step, or act as idle.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) begin
                m_ca[i] = 0; m_cb[i] = 0; m_tg[i] = 0; m_ua[i] = 0; m_ub[i] = 0;
            end
            cur   = '{busy: 0, done: 0, err: 0, st: 8'h00};
            valid = 1'b1;
        end else if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur.busy = 1'b0;
            cur.done = 1'b0;
            if (prog_we) begin
                m_ca[prog_addr] = prog_ca;
                m_cb[prog_addr] = prog_cb;
                m_tg[prog_addr] = prog_tg;
                m_ua[prog_addr] = prog_ua;
                m_ub[prog_addr] = prog_ub;
            end
            if (start) plan_run(dir, int'(len), data_in);
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            check("busy", 32'(busy), 32'(cur.busy));
            check("done", 32'(done), 32'(cur.done));
            check("err", 32'(err), 32'(cur.err));
            check("state_out", 32'(state_out), 32'(cur.st));
        end
    end

    // ---------------- stimulus ----------------
    task automatic write_entry(input int addr, input int ca, input int cb, input int tg,
                               input bit ua, input bit ub);
        @(negedge clk); #1;
        prog_we = 1'b1; prog_addr = 3'(addr);
        prog_ca = 3'(ca); prog_cb = 3'(cb); prog_tg = 3'(tg);
        prog_ua = ua; prog_ub = ub;
        @(negedge clk); #1;
        prog_we = 1'b0;
    endtask

    // Launch a run and return how many negedges after the start edge done appeared.
    // With poke set, start and an illegal write to entry 2 are pulsed mid-run.
    task automatic launch(input bit d, input int l, input bit [7:0] data, input bit poke,
                          output int lat);
        @(negedge clk); #1;
        start = 1'b1; dir = d; len = 4'(l); data_in = data;
        prog_addr = 3'd2; prog_ca = 0; prog_cb = 0; prog_tg = 0; prog_ua = 0; prog_ub = 0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done && lat < 0) lat = k;
            #1;
            start   = poke && (k == 1);
            prog_we = poke && (k == 1);
            if (poke && k == 1) begin
                len = 4'd0; data_in = 8'hFF;
            end
            if (lat >= 0 && k > 1) break;
            if (lat >= 0 && !poke) break;
        end
        start = 1'b0; prog_we = 1'b0;
    endtask

    int lat;

    initial begin
        rst_n = 1'b0; prog_we = 0; prog_addr = 0; prog_ca = 0; prog_cb = 0; prog_tg = 0;
        prog_ua = 0; prog_ub = 0; start = 0; dir = 0; len = 0; data_in = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_state", 32'(state_out), 0);
        #1 rst_n = 1'b1;

        // Single NOT
        write_entry(0, 0, 0, 2, 1, 1);
        launch(0, 1, 8'h00, 0, lat);
        check("not_lat", lat, 2);
        check("not_state", 32'(state_out), 32'h04);
        check("not_err", 32'(err), 0);

        // OR built from NOT, NOT, NAND-style Toffoli
        write_entry(0, 0, 0, 0, 1, 1);
        write_entry(1, 0, 0, 1, 1, 1);
        write_entry(2, 0, 1, 2, 0, 0);
        launch(0, 3, 8'h04, 0, lat);
        check("or00_state", 32'(state_out), 32'h03);
        check("or00_lat", lat, 4);
        launch(0, 3, 8'h06, 0, lat);
        check("or01_state", 32'(state_out), 32'h05);
        launch(0, 3, 8'h07, 0, lat);
        check("or11_state", 32'(state_out), 32'h04);

        // Uncompute: forward then reverse
        launch(0, 3, 8'h06, 0, lat);
        check("fwd_state", 32'(state_out), 32'h05);
        launch(1, 3, 8'h05, 0, lat);
        check("rev_state", 32'(state_out), 32'h06);
        check("rev_lat", lat, 4);

        // Start and prog_we during a run are ignored; program survives
        launch(0, 3, 8'h06, 1, lat);
        check("poke_state", 32'(state_out), 32'h05);
        check("poke_lat", lat, 4);
        launch(0, 3, 8'h04, 0, lat);
        check("poke_prog_kept", 32'(state_out), 32'h03);
        check("poke_prog_err", 32'(err), 0);

        // Illegal second entry aborts the run
        write_entry(0, 0, 0, 1, 1, 1);
        write_entry(1, 3, 0, 3, 0, 0);
        launch(0, 2, 8'h00, 0, lat);
        check("ill_err", 32'(err), 1);
        check("ill_state", 32'(state_out), 32'h02);
        check("ill_lat", lat, 3);

        // len = 0 completes immediately and clears err
        launch(0, 0, 8'hA5, 0, lat);
        check("len0_lat", lat, 1);
        check("len0_state", 32'(state_out), 32'hA5);
        check("len0_err", 32'(err), 0);

        // Reset mid-run clears status and program
        @(negedge clk); #1;
        start = 1'b1; dir = 0; len = 4'd3; data_in = 8'h06;
        @(negedge clk); #1;
        start = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_state", 32'(state_out), 0);
        #1 rst_n = 1'b1;
        launch(0, 3, 8'h06, 0, lat);
        check("rst_prog_err", 32'(err), 1);
        check("rst_prog_state", 32'(state_out), 32'h06);
        check("rst_prog_lat", lat, 2);

        // Randomized traffic against the model, including len clamping
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk); #1;
            rst_n     = (i != 700);
            prog_we   = ($urandom_range(0, 3) == 0);
            prog_addr = 3'($urandom_range(0, 7));
            prog_ca   = 3'($urandom_range(0, 7));
            prog_cb   = 3'($urandom_range(0, 7));
            prog_tg   = 3'($urandom_range(0, 7));
            prog_ua   = 1'($urandom_range(0, 1));
            prog_ub   = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 3) == 0);
            dir       = 1'($urandom_range(0, 1));
            len       = 4'($urandom_range(0, 15));
            data_in   = 8'($urandom);
        end
        @(negedge clk); #1;
        prog_we = 0; start = 0; rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
